// File: rtl/nl_outport_arbiter.sv
// Round-robin arbiter for one router output port with downstream credit tracking.
// Define NL_ARB_WORMHOLE_LOCK_EN to hold the port for a whole packet (head to tail).
module nl_outport_arbiter #(
   parameter int N       = 4,
   parameter int CREDITS = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic [N-1:0] tail,
   input  logic         credit_in,
   output logic [N-1:0] grant,
   output logic         xfer,
   output logic [3:0]   credit_cnt,
   output logic         locked,
   output logic         credit_err
);
   localparam int            PW      = $clog2(N);
   localparam logic [3:0]    CNT_MAX = 4'(CREDITS);
   localparam logic [PW-1:0] LAST    = PW'(N - 1);

   typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

   state_t        r_state, w_state_next;
   logic [PW-1:0] r_ptr, w_ptr_next;
   logic [PW-1:0] r_owner, w_owner_next;
   logic [PW-1:0] w_winner;
   logic          w_found;
   logic [3:0]    r_credit_cnt, w_credit_next;
   logic          r_credit_err, w_credit_err_next;
   logic [PW-1:0] w_rot_idx [N];

`ifdef NL_ARB_WORMHOLE_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
   assign locked = (r_state == ST_LOCKED);
`else
   localparam bit LOCK_EN = 1'b0;
   assign locked = 1'b0;
`endif

   function automatic logic [PW-1:0] f_wrap_inc(input logic [PW-1:0] v);
      return (v == LAST) ? '0 : v + PW'(1);
   endfunction

   // Search order ptr, ptr+1, ... modulo N.
   for (genvar gi = 0; gi < N; gi++) begin : g_rot
      assign w_rot_idx[gi] = PW'((int'(r_ptr) + gi) % N);
   end

   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      for (int k = 0; k < N; k++) begin
         if (!w_found && req[w_rot_idx[k]]) begin
            w_found  = 1'b1;
            w_winner = w_rot_idx[k];
         end
      end
   end

   // Grant depends only on registered credits, so a credit returned at zero
   // enables a grant one cycle later.
   always_comb begin
      grant = '0;
      if (rst_n && (r_credit_cnt != 4'd0)) begin
         if (r_state == ST_LOCKED) begin
            grant[r_owner] = req[r_owner];
         end else if (w_found) begin
            grant[w_winner] = 1'b1;
         end
      end
   end

   assign xfer       = |(grant & req);
   assign credit_cnt = r_credit_cnt;
   assign credit_err = r_credit_err;

   always_comb begin
      w_state_next = r_state;
      w_ptr_next   = r_ptr;
      w_owner_next = r_owner;
      case (r_state)
         ST_IDLE: begin
            if (xfer) begin
               if (LOCK_EN && !tail[w_winner]) begin
                  w_state_next = ST_LOCKED;
                  w_owner_next = w_winner;
               end else begin
                  w_ptr_next = f_wrap_inc(w_winner);
               end
            end
         end
         ST_LOCKED: begin
            if (xfer && tail[r_owner]) begin
               w_state_next = ST_IDLE;
               w_ptr_next   = f_wrap_inc(r_owner);
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_credit_next     = r_credit_cnt;
      w_credit_err_next = 1'b0;
      if (xfer && !credit_in) begin
         w_credit_next = r_credit_cnt - 4'd1;
      end else if (credit_in && !xfer) begin
         if (r_credit_cnt == CNT_MAX) begin
            w_credit_err_next = 1'b1;
         end else begin
            w_credit_next = r_credit_cnt + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_ptr        <= '0;
         r_owner      <= '0;
         r_credit_cnt <= CNT_MAX;
         r_credit_err <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_ptr        <= w_ptr_next;
         r_owner      <= w_owner_next;
         r_credit_cnt <= w_credit_next;
         r_credit_err <= w_credit_err_next;
      end
   end

endmodule
